// File: rtl/md_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, 32 iterations plus a sign-fix cycle.
module md_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic                 is_div_q, is_div_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 a_neg, b_neg, div_zero;
    logic [WIDTH-1:0]     a_mag, b_mag, dividend;
    logic [WIDTH:0]       mul_sum, div_shift, div_trial;
    logic                 div_ok;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    always_comb begin
        a_neg     = ~op[0] & A[WIDTH-1];
        b_neg     = ~op[0] & B[WIDTH-1];
        a_mag     = a_neg ? -A : A;
        b_mag     = b_neg ? -B : B;
        div_zero  = op[1] & (B == '0);
        // Divide by zero runs the unsigned path on the raw dividend, which
        // naturally yields an all-ones quotient and the dividend as remainder.
        dividend  = div_zero ? A : a_mag;

        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, mcand_q};
        div_ok    = ~div_trial[WIDTH];

        prod_fix  = qneg_q ? -acc_q : acc_q;
        quot_fix  = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        is_div_d = is_div_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    if (!op[2]) begin
                        state_d  = op[1] ? S_DIV : S_MUL;
                        cnt_d    = '0;
                        is_div_d = op[1];
                        mcand_d  = op[1] ? b_mag : a_mag;
                        acc_d    = {{WIDTH{1'b0}}, op[1] ? dividend : b_mag};
                        qneg_d   = (a_neg ^ b_neg) & ~div_zero;
                        rneg_d   = a_neg & ~div_zero;
                    end else if (!op[1]) begin
                        if (op[0]) lo_d = A;
                        else       hi_d = A;
                    end
                end
            end
            S_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
            end
            S_DIV: begin
                acc_d = div_ok ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                               : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    lo_d = quot_fix;
                    hi_d = rem_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A flush kills whatever is in flight, including a pending FIX write.
        if (flush && state_q != S_IDLE) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            is_div_q <= is_div_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed literal cases plus randomized traffic
// compared every cycle against a cycle-count/arithmetic reference model.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        flush;
    logic        busy, done;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;

    md_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .flush(flush), .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result {HI,LO} computed with plain integer arithmetic.
    function automatic logic [63:0] md_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, p, q, r;
        sa = o[0] ? $signed({32'b0, a}) : $signed({{32{a[31]}}, a});
        sb = o[0] ? $signed({32'b0, b}) : $signed({{32{b[31]}}, b});
        if (!o[1]) begin
            p = sa * sb;
            return p;
        end
        if (b == 32'b0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Reference model: remaining busy cycles and the pending result.
    int          m_left;
    logic [63:0] m_res;
    logic [31:0] m_hi, m_lo;
    logic        m_done;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left = 0; m_hi = 0; m_lo = 0; m_done = 0; m_res = 0;
        end else begin
            m_done = 0;
            if (flush) begin
                m_left = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = m_res[63:32];
                    m_lo = m_res[31:0];
                    m_done = 1;
                end
            end else if (start) begin
                if (op == 3'd4) m_hi = A;
                else if (op == 3'd5) m_lo = A;
                else if (op < 3'd4) begin
                    m_res  = md_result(op, A, B);
                    m_left = 33;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("cyc busy", {31'b0, busy}, {31'b0, m_left > 0});
            chk("cyc done", {31'b0, done}, {31'b0, m_done});
            chk("cyc HI", HI, m_hi);
            chk("cyc LO", LO, m_lo);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        start = 1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 0;
        chk({nm, " busy"}, {31'b0, busy}, 32'd1);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'd33);
        chk({nm, " HI"}, HI, exp_hi);
        chk({nm, " LO"}, LO, exp_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dones;
        rst = 0; start = 0; op = 0; A = 0; B = 0; flush = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset HI", HI, 32'h0);
        rst = 1;
        @(posedge clk); #1;
        chk("post reset done", {31'b0, done}, 32'd0);
        chk("post reset LO", LO, 32'h0);

        do_op("mult -3*5", 3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        chk("done pulse end", {31'b0, done}, 32'd1);
        @(posedge clk); #1;
        chk("done one cycle", {31'b0, done}, 32'd0);
        do_op("multu ff*ff", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        do_op("mult -1*-1", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);
        do_op("div -7/2", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("divu 7/2", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3);
        do_op("divu 100/0", 3'd3, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
        do_op("div ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        do_op("div -5/0", 3'd2, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);

        start = 1; op = 3'd4; A = 32'h12345678;
        @(posedge clk); #1;
        chk("mthi HI", HI, 32'h12345678);
        op = 3'd5; A = 32'h9ABCDEF0;
        @(posedge clk); #1;
        start = 0;
        chk("mtlo LO", LO, 32'h9ABCDEF0);
        chk("mtlo busy", {31'b0, busy}, 32'd0);
        chk("mtlo done", {31'b0, done}, 32'd0);

        start = 1; op = 3'd2; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        start = 0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        chk("flush busy", {31'b0, busy}, 32'd0);
        dones = 0;
        repeat (40) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        chk("flush no done", 32'(dones), 32'd0);
        chk("flush HI", HI, 32'h12345678);
        chk("flush LO", LO, 32'h9ABCDEF0);

        start = 1; op = 3'd4; A = 32'hDEAD0000; flush = 1;
        @(posedge clk); #1;
        start = 0; flush = 0;
        chk("flush blocks mthi", HI, 32'h12345678);

        start = 1; op = 3'd0; A = 32'd9; B = 32'd9;
        @(posedge clk); #1;
        start = 0;
        repeat (19) begin @(posedge clk); #1; end
        #2 rst = 0;
        #1;
        chk("async rst busy", {31'b0, busy}, 32'd0);
        chk("async rst HI", HI, 32'h0);
        chk("async rst LO", LO, 32'h0);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;

        do_op("b2b first", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12);
        do_op("b2b second", 3'd0, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFA);

        repeat (3000) begin
            start = ($urandom_range(0, 3) == 0);
            op    = 3'($urandom_range(0, 7));
            A     = pick();
            B     = pick();
            flush = ($urandom_range(0, 60) == 0);
            @(posedge clk); #1;
        end
        start = 0; flush = 0;
        repeat (40) begin @(posedge clk); #1; end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
